// File: rtl/prio_enc_arb.sv
// Registered priority encoder / arbiter: sticky pending bits, one offered index at a time over
// a valid/ack handshake, fixed (highest index wins) or rotating priority.

module prio_enc_arb_lane (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic mask,
    input  logic clr,
    output logic pend,
    output logic elig
);

    // A new event in the same cycle as the clear keeps the bit pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= 1'b0;
        else     pend <= (pend & ~clr) | req;
    end

    // The bit being acknowledged this cycle cannot win the next offer.
    assign elig = pend & ~mask & ~clr;

endmodule

module prio_enc_arb #(
    parameter int N           = 8,
    parameter int W           = $clog2(N),
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [W-1:0] grant_idx,
    output logic         grant_vld,
    input  logic         grant_ack,
    output logic [N-1:0] pend,
    output logic         any_pend
);

    typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   idx_nx;
    logic [W-1:0]   sel_idx;
    logic [W-1:0]   rr_ptr;
    logic [N-1:0]   clr;
    logic [N-1:0]   elig;
    logic           accept;
    logic           found;

    assign accept    = grant_vld & grant_ack;
    assign grant_vld = (state == OFFER);
    assign any_pend  = |pend;

    always_comb begin
        clr = '0;
        for (int i = 0; i < N; i++)
            clr[i] = accept && (grant_idx == W'(i));
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        prio_enc_arb_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .req  (req[g]),
            .mask (mask[g]),
            .clr  (clr[g]),
            .pend (pend[g]),
            .elig (elig[g])
        );
    end

    // Fixed: last set bit found scanning upward is the highest index.
    // Rotating: scan downward from rr_ptr-1 with wrap, so rr_ptr itself comes last.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        if (!ROUND_ROBIN) begin
            for (int i = 0; i < N; i++)
                if (elig[i]) sel_idx = W'(i);
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!found && elig[(int'(rr_ptr) + N - k) % N]) begin
                    found   = 1'b1;
                    sel_idx = W'((int'(rr_ptr) + N - k) % N);
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = grant_idx;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nx = OFFER;
                    idx_nx   = sel_idx;
                end else begin
                    idx_nx   = '0;
                end
            end
            OFFER: begin
                if (grant_ack) begin
                    if (|elig) begin
                        state_nx = OFFER;
                        idx_nx   = sel_idx;
                    end else begin
                        state_nx = IDLE;
                        idx_nx   = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= '0;
            rr_ptr    <= W'(N - 1);
        end else begin
            state     <= state_nx;
            grant_idx <= idx_nx;
            if (accept) rr_ptr <= grant_idx;
        end
    end

endmodule

// File: tb/tb_prio_enc_arb.sv
// Bench for prio_enc_arb: a fixed-priority and a round-robin instance driven side by side,
// checked against directed expectations and a cycle-level model of the arbitration rules.

module tb_prio_enc_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       grant_ack;

    logic [2:0] fx_idx, rr_idx;
    logic       fx_vld, rr_vld;
    logic [7:0] fx_pend, rr_pend;
    logic       fx_any, rr_any;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state; index 0 = fixed priority, 1 = round robin.
    logic [7:0] m_pend [2];
    bit         m_vld  [2];
    int         m_idx  [2];
    int         m_ptr  [2];

    always #5 clk = ~clk;

    prio_enc_arb #(.N(8), .ROUND_ROBIN(1'b0)) dut_fx (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .grant_idx(fx_idx), .grant_vld(fx_vld), .grant_ack(grant_ack),
        .pend(fx_pend), .any_pend(fx_any)
    );

    prio_enc_arb #(.N(8), .ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .mask(mask),
        .grant_idx(rr_idx), .grant_vld(rr_vld), .grant_ack(grant_ack),
        .pend(rr_pend), .any_pend(rr_any)
    );

    function automatic int pick(int mode, logic [7:0] e, int ptr);
        if (mode == 0) begin
            for (int i = 7; i >= 0; i--) if (e[i]) return i;
        end else begin
            for (int d = 1; d <= 8; d++) if (e[(ptr - d + 8) % 8]) return (ptr - d + 8) % 8;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = 8'h00; m_vld[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7;
        end
    endtask

    task automatic model_step();
        logic [7:0] clrv, e;
        bit acc;
        int old_idx;
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_pend[m] = 8'h00; m_vld[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7;
            end else begin
                acc     = m_vld[m] && grant_ack;
                old_idx = m_idx[m];
                clrv    = acc ? (8'h01 << old_idx) : 8'h00;
                e       = m_pend[m] & ~mask & ~clrv;
                m_pend[m] = (m_pend[m] & ~clrv) | req;
                if (!m_vld[m] || grant_ack) begin
                    if (e != 0) begin m_vld[m] = 1'b1; m_idx[m] = pick(m, e, m_ptr[m]); end
                    else        begin m_vld[m] = 1'b0; m_idx[m] = 0; end
                end
                if (acc) m_ptr[m] = old_idx;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; mask = '0; grant_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({fx_vld, fx_idx, fx_pend, fx_any} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_fx: got vld=%0b idx=%0d pend=%h any=%0b, want all 0", fx_vld, fx_idx, fx_pend, fx_any);
        end
        n_cmp++;
        if ({rr_vld, rr_idx, rr_pend, rr_any} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_rr: got vld=%0b idx=%0d pend=%h any=%0b, want all 0", rr_vld, rr_idx, rr_pend, rr_any);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({fx_vld, rr_vld, fx_pend, rr_pend} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_idle: got vld=%0b/%0b pend=%h/%h, want 0", fx_vld, rr_vld, fx_pend, rr_pend);
        end
    endtask

    // 8'h2C for one cycle, ack held: 5, 3, 2 back to back, then drained.
    task automatic test_fixed_seq();
        int exp_seq [3] = '{5, 3, 2};
        grant_ack = 1'b1; req = 8'h2C;
        tick();
        req = 8'h00;
        n_cmp++;
        if (fx_pend !== 8'h2C || fx_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_latch: got pend=%h vld=%0b, want pend=2c vld=0", fx_pend, fx_vld);
        end
        for (int j = 0; j < 3; j++) begin
            tick();
            n_cmp++;
            if (fx_vld !== 1'b1 || fx_idx !== 3'(exp_seq[j]) || rr_vld !== 1'b1 || rr_idx !== 3'(exp_seq[j])) begin
                n_fail++;
                $display("FAIL seq_grant%0d: got fx %0b/%0d rr %0b/%0d, want 1/%0d", j, fx_vld, fx_idx, rr_vld, rr_idx, exp_seq[j]);
            end
        end
        tick();
        n_cmp++;
        if (fx_vld !== 1'b0 || fx_pend !== 8'h00 || fx_any !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_drain: got vld=%0b pend=%h any=%0b, want 0/00/0", fx_vld, fx_pend, fx_any);
        end
        grant_ack = 1'b0;
    endtask

    // Live offer of 3 must not be displaced by a higher request.
    task automatic test_hold();
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        req = 8'h80;
        tick();
        req = 8'h00;
        repeat (3) begin
            tick();
            n_cmp++;
            if (fx_vld !== 1'b1 || fx_idx !== 3'd3 || rr_idx !== 3'd3) begin
                n_fail++;
                $display("FAIL hold_stable: got fx %0b/%0d rr %0d, want 1/3", fx_vld, fx_idx, rr_idx);
            end
        end
        grant_ack = 1'b1;
        tick();
        n_cmp++;
        if (fx_vld !== 1'b1 || fx_idx !== 3'd7 || rr_idx !== 3'd7) begin
            n_fail++;
            $display("FAIL hold_next: got fx %0b/%0d rr %0d, want 1/7", fx_vld, fx_idx, rr_idx);
        end
        tick();
        grant_ack = 1'b0;
    endtask

    // Lines 7 and 0 kept pending by continuous re-requests; rotation must alternate.
    task automatic test_rr();
        int prev = -1;
        grant_ack = 1'b1; req = 8'h81;
        tick();
        for (int j = 0; j < 6; j++) begin
            tick();
            n_cmp++;
            if (rr_vld !== 1'b1 || !(rr_idx == 3'd0 || rr_idx == 3'd7) || int'(rr_idx) == prev) begin
                n_fail++;
                $display("FAIL rr_alternate%0d: got vld=%0b idx=%0d prev=%0d, want the other of 0/7", j, rr_vld, rr_idx, prev);
            end
            prev = int'(rr_idx);
            n_cmp++;
            if (fx_vld !== m_vld[0] || int'(fx_idx) !== m_idx[0]) begin
                n_fail++;
                $display("FAIL rr_fixed_ref%0d: got %0b/%0d, want %0b/%0d", j, fx_vld, fx_idx, m_vld[0], m_idx[0]);
            end
        end
        req = 8'h00;
        repeat (3) tick();
        grant_ack = 1'b0;
        n_cmp++;
        if (fx_any !== 1'b0 || rr_any !== 1'b0 || fx_vld !== 1'b0 || rr_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain: got any=%0b/%0b vld=%0b/%0b, want 0", fx_any, rr_any, fx_vld, rr_vld);
        end
    endtask

    task automatic test_mask();
        bit seen = 1'b0;
        mask = 8'h10; req = 8'h10;
        tick();
        req = 8'h00;
        repeat (2) tick();
        n_cmp++;
        if (fx_vld !== 1'b0 || fx_any !== 1'b1 || fx_pend !== 8'h10 || rr_vld !== 1'b0 || rr_any !== 1'b1) begin
            n_fail++;
            $display("FAIL mask_block: got vld=%0b/%0b any=%0b/%0b pend=%h, want 0/0 1/1 10", fx_vld, rr_vld, fx_any, rr_any, fx_pend);
        end
        mask = 8'h00;
        for (int j = 0; j < 2 && !seen; j++) begin
            tick();
            seen = fx_vld && fx_idx == 3'd4 && rr_vld && rr_idx == 3'd4;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL mask_release: got fx %0b/%0d rr %0b/%0d, want 1/4 within 2 edges", fx_vld, fx_idx, rr_vld, rr_idx);
        end
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
    endtask

    task automatic test_ack_req();
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        grant_ack = 1'b1; req = 8'h04;
        tick();
        grant_ack = 1'b0; req = 8'h00;
        n_cmp++;
        if (fx_pend[2] !== 1'b1 || rr_pend[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL ackreq_pend: got pend=%h/%h, want bit2 set", fx_pend, rr_pend);
        end
        tick();
        n_cmp++;
        if (fx_vld !== 1'b1 || fx_idx !== 3'd2 || rr_vld !== 1'b1 || rr_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL ackreq_reoffer: got fx %0b/%0d rr %0b/%0d, want 1/2", fx_vld, fx_idx, rr_vld, rr_idx);
        end
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid();
        req = 8'hFF;
        tick();
        req = 8'h00;
        tick();
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({fx_vld, fx_idx, fx_pend, fx_any, rr_vld, rr_idx, rr_pend, rr_any} !== 26'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got fx %0b/%0d/%h rr %0b/%0d/%h, want 0", fx_vld, fx_idx, fx_pend, rr_vld, rr_idx, rr_pend);
        end
        tick();
        rst = 1'b0; req = 8'h01;
        tick();
        req = 8'h00;
        n_cmp++;
        if (fx_vld !== 1'b0 || fx_pend !== 8'h01) begin
            n_fail++;
            $display("FAIL rst_after_latch: got vld=%0b pend=%h, want 0/01", fx_vld, fx_pend);
        end
        tick();
        n_cmp++;
        if (fx_vld !== 1'b1 || fx_idx !== 3'd0 || rr_vld !== 1'b1 || rr_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_after_offer: got fx %0b/%0d rr %0b/%0d, want 1/0", fx_vld, fx_idx, rr_vld, rr_idx);
        end
        grant_ack = 1'b1;
        tick();
        grant_ack = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req       = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            grant_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom) & 8'($urandom);
            tick();
            n_cmp++;
            if (fx_vld !== m_vld[0] || (m_vld[0] && int'(fx_idx) !== m_idx[0]) ||
                fx_pend !== m_pend[0] || fx_any !== (m_pend[0] != 0)) begin
                n_fail++;
                $display("FAIL rand_fx c=%0d: got %0b/%0d/%h, want %0b/%0d/%h", c, fx_vld, fx_idx, fx_pend, m_vld[0], m_idx[0], m_pend[0]);
            end
            n_cmp++;
            if (rr_vld !== m_vld[1] || (m_vld[1] && int'(rr_idx) !== m_idx[1]) ||
                rr_pend !== m_pend[1] || rr_any !== (m_pend[1] != 0)) begin
                n_fail++;
                $display("FAIL rand_rr c=%0d: got %0b/%0d/%h, want %0b/%0d/%h", c, rr_vld, rr_idx, rr_pend, m_vld[1], m_idx[1], m_pend[1]);
            end
        end
        req = 8'h00; mask = 8'h00; grant_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fixed_seq();
        test_hold();
        test_rr();
        test_mask();
        test_ack_req();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
